// File: rtl/insn_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package insn_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam int INSN_W = 32;
    localparam int PC_W   = 64;
    localparam int OFF_W  = 26;
    localparam int CNT_W  = 32;

    localparam logic [PC_W-1:0] PC_INC = 64'd4;

    localparam logic RK_REL = 1'b0;
    localparam logic RK_REG = 1'b1;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/insn_fetch_unit_if.sv
// Memory-side and decode-side handshakes of the fetch stage; master is the fetch unit.
interface insn_fetch_unit_if;
    import insn_fetch_unit_pkg::*;

    logic                     imem_req;
    logic [PC_W-1:0]          imem_addr;
    logic                     imem_ack;
    logic [INSN_W-1:0]        imem_data;
    logic [INSN_W-1:0]        insn;
    logic [PC_W-1:0]          insn_pc;
    logic                     insn_valid;
    logic                     insn_ready;
    logic                     redirect;
    logic                     redirect_kind;
    logic signed [OFF_W-1:0]  br_offset;
    logic [PC_W-1:0]          br_reg;

    modport master (
        output imem_req, imem_addr, insn, insn_pc, insn_valid,
        input  imem_ack, imem_data, insn_ready, redirect, redirect_kind, br_offset, br_reg
    );

    modport slave (
        input  imem_req, imem_addr, insn, insn_pc, insn_valid,
        output imem_ack, imem_data, insn_ready, redirect, redirect_kind, br_offset, br_reg
    );

endinterface

// File: rtl/insn_fetch_unit_branch_target_calc.sv
// Branch target: PC-relative word offset or register-indirect, always word aligned.
module branch_target_calc
    import insn_fetch_unit_pkg::*;
(
    input  logic [PC_W-1:0]         insn_pc_i,
    input  logic signed [OFF_W-1:0] br_offset_i,
    input  logic [PC_W-1:0]         br_reg_i,
    input  logic                    redirect_kind_i,
    output logic [PC_W-1:0]         target_o
);

    logic signed [PC_W-1:0] off_ext;
    logic [PC_W-1:0]        raw;

    assign off_ext  = {{(PC_W-OFF_W-2){br_offset_i[OFF_W-1]}}, br_offset_i, 2'b00};
    assign raw      = (redirect_kind_i == RK_REG) ? br_reg_i : insn_pc_i + off_ext;
    assign target_o = raw & ~64'd3;

endmodule

// File: rtl/insn_fetch_unit.sv
// Fetch stage: PC, one-outstanding imem request, held instruction and branch redirect.
// Optional FETCH_PERF_EN adds saturating fetch/stall counters.
module insn_fetch_unit
    import insn_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic               clock,
    input  logic               reset,
    insn_fetch_unit_if.master  bus,
`ifdef FETCH_PERF_EN
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   stall_count,
`endif
    output logic [PC_W-1:0]    pc
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSN_W-1:0]   insn_q, insn_d;
    logic [PC_W-1:0]     insn_pc_q, insn_pc_d;
    logic [PC_W-1:0]     target;

    branch_target_calc u_btc (
        .insn_pc_i       (insn_pc_q),
        .br_offset_i     (bus.br_offset),
        .br_reg_i        (bus.br_reg),
        .redirect_kind_i (bus.redirect_kind),
        .target_o        (target)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        insn_d    = insn_q;
        insn_pc_d = insn_pc_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (bus.imem_ack) begin
                    insn_d    = bus.imem_data;
                    insn_pc_d = pc_q;
                    pc_d      = pc_q + PC_INC;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                // pc already points past insn_pc, so only a taken branch touches it.
                if (bus.insn_ready) begin
                    if (bus.redirect) pc_d = target;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            insn_q    <= '0;
            insn_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            insn_q    <= insn_d;
            insn_pc_q <= insn_pc_d;
        end
    end

    assign bus.imem_req   = (state_q == S_REQ);
    assign bus.imem_addr  = pc_q;
    assign bus.insn       = insn_q;
    assign bus.insn_pc    = insn_pc_q;
    assign bus.insn_valid = (state_q == S_HOLD);
    assign pc             = pc_q;

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_REQ && bus.imem_ack) fetch_cnt_d = sat_inc(fetch_cnt_q);
        if ((state_q == S_REQ && !bus.imem_ack) || (state_q == S_HOLD && !bus.insn_ready))
            stall_cnt_d = sat_inc(stall_cnt_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Directed bench for insn_fetch_unit; perf counter checks compiled in with FETCH_PERF_EN.
module tb_insn_fetch_unit;
    import insn_fetch_unit_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [63:0] pc;
    int checks = 0;
    int failures = 0;

    insn_fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, stall_count;
    logic [31:0] stall0;
`endif

    insn_fetch_unit #(.RESET_PC(64'h0)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
`ifdef FETCH_PERF_EN
        .fetch_count (fetch_count),
        .stall_count (stall_count),
`endif
        .pc          (pc)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        bus.imem_ack      = 1'b0;
        bus.imem_data     = '0;
        bus.insn_ready    = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_kind = 1'b0;
        bus.br_offset     = '0;
        bus.br_reg        = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 64'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", bus.imem_addr); end
        checks++; if (bus.insn !== 32'h0) begin failures++; $display("FAIL rst_insn got=%h exp=0", bus.insn); end
        checks++; if (bus.insn_pc !== 64'h0) begin failures++; $display("FAIL rst_insn_pc got=%h exp=0", bus.insn_pc); end
        checks++; if (bus.insn_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.insn_valid); end
        checks++; if (pc !== 64'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", pc); end
`ifdef FETCH_PERF_EN
        checks++; if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin failures++; $display("FAIL rst_perf got=%h/%h exp=0/0", fetch_count, stall_count); end
`endif
        reset = 1'b0;
        // Cycle 1 after deassert is still S_IDLE.
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL idle_req got=%b exp=0", bus.imem_req); end
    endtask

    task automatic test_zero_wait;
        bus.imem_ack   = 1'b1;
        bus.imem_data  = 32'h8B020020;
        bus.insn_ready = 1'b1;
        step();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin failures++; $display("FAIL zw_req got=%b/%h exp=1/0", bus.imem_req, bus.imem_addr); end
        checks++; if (bus.insn_valid !== 1'b0) begin failures++; $display("FAIL zw_nvalid got=%b exp=0", bus.insn_valid); end
        step();
        checks++; if (bus.insn_valid !== 1'b1 || bus.imem_req !== 1'b0) begin failures++; $display("FAIL zw_valid got=%b/%b exp=1/0", bus.insn_valid, bus.imem_req); end
        checks++; if (bus.insn !== 32'h8B020020 || bus.insn_pc !== 64'h0) begin failures++; $display("FAIL zw_insn got=%h/%h exp=8b020020/0", bus.insn, bus.insn_pc); end
        checks++; if (pc !== 64'h4) begin failures++; $display("FAIL zw_pc got=%h exp=4", pc); end
        step();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h4) begin failures++; $display("FAIL zw_next got=%b/%h exp=1/4", bus.imem_req, bus.imem_addr); end
        bus.imem_ack   = 1'b0;
        bus.insn_ready = 1'b0;
    endtask

    task automatic test_delayed_ack;
`ifdef FETCH_PERF_EN
        stall0 = stall_count;
`endif
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h4 || bus.insn_valid !== 1'b0) begin
                failures++; $display("FAIL dly_hold[%0d] got=%b/%h/%b exp=1/4/0", i, bus.imem_req, bus.imem_addr, bus.insn_valid);
            end
            if (i < 3) step();
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'hF84003E0;
        step();
        bus.imem_ack  = 1'b0;
        checks++; if (bus.insn_valid !== 1'b1 || bus.insn !== 32'hF84003E0 || bus.insn_pc !== 64'h4) begin
            failures++; $display("FAIL dly_insn got=%b/%h/%h exp=1/f84003e0/4", bus.insn_valid, bus.insn, bus.insn_pc);
        end
`ifdef FETCH_PERF_EN
        checks++; if (stall_count !== stall0 + 32'd3) begin failures++; $display("FAIL dly_stall got=%0d exp=%0d", stall_count, stall0 + 32'd3); end
        checks++; if (fetch_count !== 32'd2) begin failures++; $display("FAIL dly_fetch got=%0d exp=2", fetch_count); end
`endif
    endtask

    task automatic test_ready_low;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.insn_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.insn !== 32'hF84003E0 || bus.insn_pc !== 64'h4) begin
                failures++; $display("FAIL rl_hold[%0d] got=%b/%b/%h/%h exp=1/0/f84003e0/4", i, bus.insn_valid, bus.imem_req, bus.insn, bus.insn_pc);
            end
            step();
        end
`ifdef FETCH_PERF_EN
        checks++; if (stall_count !== stall0 + 32'd8) begin failures++; $display("FAIL rl_stall got=%0d exp=%0d", stall_count, stall0 + 32'd8); end
`endif
        bus.insn_ready = 1'b1;
        step();
        bus.insn_ready = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h8) begin failures++; $display("FAIL rl_next got=%b/%h exp=1/8", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_redirect;
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'h17FFFFFE;
        step();
        bus.imem_ack      = 1'b0;
        bus.insn_ready    = 1'b1;
        bus.redirect      = 1'b1;
        bus.redirect_kind = RK_REG;
        bus.br_reg        = 64'h100;
        step();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h100) begin failures++; $display("FAIL rd_br got=%b/%h exp=1/100", bus.imem_req, bus.imem_addr); end
        // Redirect still high in S_REQ must be ignored.
        bus.br_reg   = 64'h5550;
        bus.imem_ack = 1'b1;
        step();
        checks++; if (bus.insn_pc !== 64'h100 || pc !== 64'h104) begin failures++; $display("FAIL rd_ign got=%h/%h exp=100/104", bus.insn_pc, pc); end
        bus.imem_ack      = 1'b0;
        bus.redirect_kind = RK_REL;
        bus.br_offset     = -26'sd2;
        step();
        checks++; if (bus.imem_addr !== 64'hF8) begin failures++; $display("FAIL rd_rel got=%h exp=f8", bus.imem_addr); end
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack      = 1'b0;
        bus.redirect_kind = RK_REG;
        bus.br_reg        = 64'h2003;
        step();
        checks++; if (bus.imem_addr !== 64'h2000) begin failures++; $display("FAIL rd_reg got=%h exp=2000", bus.imem_addr); end
        bus.redirect   = 1'b0;
        bus.insn_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        reset = 1'b1;
        step();
        checks++; if (bus.imem_req !== 1'b0 || bus.insn_valid !== 1'b0 || pc !== 64'h0) begin
            failures++; $display("FAIL rm_idle got=%b/%b/%h exp=0/0/0", bus.imem_req, bus.insn_valid, pc);
        end
        checks++; if (bus.insn !== 32'h0 || bus.insn_pc !== 64'h0) begin failures++; $display("FAIL rm_data got=%h/%h exp=0/0", bus.insn, bus.insn_pc); end
        reset         = 1'b0;
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'hDEADBEEF;
        step();
        bus.imem_ack = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0 || bus.insn_valid !== 1'b0 || bus.insn !== 32'h0) begin
            failures++; $display("FAIL rm_drop got=%b/%h/%b/%h exp=1/0/0/0", bus.imem_req, bus.imem_addr, bus.insn_valid, bus.insn);
        end
        step();
        checks++; if (bus.imem_req !== 1'b1 || bus.insn_valid !== 1'b0) begin failures++; $display("FAIL rm_wait got=%b/%b exp=1/0", bus.imem_req, bus.insn_valid); end
`ifdef FETCH_PERF_EN
        checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL rm_fetch got=%0d exp=0", fetch_count); end
`endif
    endtask

    task automatic test_back_to_back;
        logic        exp_req [4];
        logic [63:0] exp_adr [4];
        exp_req = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_adr = '{64'h0, 64'h0, 64'h4, 64'h4};
        bus.imem_ack   = 1'b1;
        bus.imem_data  = 32'h91000421;
        bus.insn_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.imem_req !== exp_req[i] || bus.insn_valid !== !exp_req[i] ||
                (exp_req[i] ? bus.imem_addr : bus.insn_pc) !== exp_adr[i]) begin
                failures++; $display("FAIL b2b[%0d] got=%b/%b/%h/%h exp_req=%b addr=%h", i, bus.imem_req, bus.insn_valid, bus.imem_addr, bus.insn_pc, exp_req[i], exp_adr[i]);
            end
            step();
        end
        bus.imem_ack   = 1'b0;
        bus.insn_ready = 1'b0;
        checks++; if (bus.imem_addr !== 64'h8) begin failures++; $display("FAIL b2b_end got=%h exp=8", bus.imem_addr); end
    endtask

    task automatic test_wrap;
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack      = 1'b0;
        bus.insn_ready    = 1'b1;
        bus.redirect      = 1'b1;
        bus.redirect_kind = RK_REG;
        bus.br_reg        = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        checks++; if (bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wr_top got=%h exp=fffffffffffffffc", bus.imem_addr); end
        bus.redirect   = 1'b0;
        bus.insn_ready = 1'b0;
        bus.imem_ack   = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        checks++; if (bus.insn_pc !== 64'hFFFF_FFFF_FFFF_FFFC || pc !== 64'h0) begin failures++; $display("FAIL wr_pc got=%h/%h exp=fffffffffffffffc/0", bus.insn_pc, pc); end
        bus.insn_ready = 1'b1;
        step();
        bus.insn_ready = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin failures++; $display("FAIL wr_next got=%b/%h exp=1/0", bus.imem_req, bus.imem_addr); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_ready_low();
        test_redirect();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/insn_fetch_unit.md
# insn_fetch_unit

Instruction fetch stage upstream of the LEGv8 datapath. It holds the program counter, fetches 32-bit instructions from instruction memory over a req/ack handshake, and presents each instruction with its PC to the decode/control logic over a valid/ready handshake. When the consumer accepts a branch, it applies the redirect to the PC (PC-relative or register-indirect).

## Interface
Parameters:
- RESET_PC, 64'h0: PC loaded on reset; bits [1:0] must be 0.

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request; held until ack
- imem_addr  out  64  fetch address, equal to pc while imem_req=1
- imem_ack  in  1  imem_data valid this cycle; may arrive in the same cycle as imem_req
- imem_data  in  32  fetched instruction word
- insn  out  32  held instruction
- insn_pc  out  64  address of insn
- insn_valid  out  1  insn/insn_pc valid
- insn_ready  in  1  consumer accepts insn this cycle
- redirect  in  1  consumed insn is a taken branch; sampled only on accept
- redirect_kind  in  1  0: target = insn_pc + (sext(br_offset) << 2); 1: target = br_reg
- br_offset  in  26  signed word offset; the caller sign-extends CB-format 19-bit fields to 26 bits
- br_reg  in  64  register value for BR
- pc  out  64  next fetch address

## Operation
- FSM states: S_IDLE, S_REQ, S_HOLD.
- S_IDLE: entered on reset; all outputs at reset values; moves to S_REQ next cycle. imem_ack is ignored.
- S_REQ: imem_req=1, imem_addr=pc. On imem_ack: insn<=imem_data, insn_pc<=pc, pc<=pc+4, go to S_HOLD. With no ack, stay and hold the request.
- S_HOLD: insn_valid=1, imem_req=0. On insn_ready:
  - redirect=1: pc<=target.
  - redirect=0: pc keeps its value, already insn_pc+4.
  - In both cases go to S_REQ.
  Without insn_ready, stay and hold all outputs stable.
- redirect/redirect_kind/br_* are ignored unless insn_valid&insn_ready.
- Target arithmetic is 64-bit modulo 2^64. target[1:0] is forced to 2'b00, so br_reg low bits are dropped. pc+4 wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0.
- At most one outstanding request exists, and redirects only occur with no fetch in flight, so no flush logic is needed.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, insn=0, insn_pc=0, insn_valid=0, pc=RESET_PC.
- First imem_req is in the 2nd cycle after reset deasserts (1 cycle in S_IDLE).
- Best case with zero-wait ack and ready held high: 1 instruction per 2 cycles (S_REQ, S_HOLD alternate).
- Latency from ack to insn_valid is 1 cycle (registered).
- Redirect target appears on imem_addr the cycle after accept.
- Reset is asserted mid-operation, in any state: at the next edge, go to S_IDLE with reset values. An in-flight fetch is abandoned; an ack arriving in S_IDLE is dropped.

## Configuration
- FETCH_PERF_EN defined: adds outputs fetch_count (out, 32) and stall_count (out, 32). Both reset to 0. fetch_count increments on each imem_ack in S_REQ. stall_count increments on each cycle in S_REQ without ack, plus each cycle in S_HOLD without ready. Both saturate at 32'hFFFF_FFFF.
- FETCH_PERF_EN undefined: neither port nor counter exists; the rest of the behaviour is identical.

## Structure
- Shared package:
  - state encoding (S_IDLE, S_REQ, S_HOLD)
  - INSN_W=32, PC_W=64, PC_INC=64'd4
  - redirect kind constants RK_REL=1'b0, RK_REG=1'b1
- One sub-module, branch_target_calc: combinational; inputs insn_pc, br_offset, br_reg, redirect_kind; output 64-bit aligned target.

## Test plan
- Reset, then zero-wait ack with imem_data=32'h8B020020 and ready=1 -> imem_req in cycle 2 at addr 0; insn_valid in cycle 3 with insn_pc=0; next req at addr 4.
- Ack delayed 3 cycles -> imem_req and imem_addr stay stable throughout; insn_valid only after ack; stall_count=3 when FETCH_PERF_EN is defined.
- Ready held low 5 cycles with insn_valid=1 -> insn and insn_pc unchanged, no imem_req; accept on cycle 6 -> req at insn_pc+4.
- Accept at insn_pc=0x100 with redirect=1, kind=0, br_offset=-2 -> next imem_addr=0xF8; kind=1 with br_reg=0x2003 -> 0x2000.
- pc=64'hFFFF_FFFF_FFFF_FFFC, fetch without redirect -> next imem_addr=0.
- Reset asserted while waiting for an ack, ack arrives the following cycle -> ack ignored, insn_valid stays 0, refetch starts from RESET_PC.
